vco_adc_seq: RTL and testbench

//  Conversion sequencer for vco_adc. Accepts a burst command (oversample ratio, sample count), drives adc_enable_out/adc_oversample_out.

---
 rtl/vco_adc_seq_pkg.sv | 14 +
 rtl/vco_adc_seq_if.sv | 24 ++
 rtl/vco_adc_seq_sync_fifo.sv | 45 ++++
 rtl/vco_adc_seq.sv | 123 ++++++++++++
 tb/tb_vco_adc_seq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vco_adc_seq_pkg.sv
// Shared definitions for the vco_adc conversion sequencer.
package vco_adc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside status_out = {timeout, overrun}
  localparam int unsigned STAT_OVR = 0;
  localparam int unsigned STAT_TO  = 1;

endpackage

// File: rtl/vco_adc_seq_if.sv
// Command and result channels between the bus layer (master) and the sequencer (slave).
interface vco_adc_seq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OSR_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  req_valid_in;
  logic                  req_ready_out;
  logic [OSR_WIDTH-1:0]  req_osr_in;
  logic [CNT_WIDTH-1:0]  req_count_in;
  logic [DATA_WIDTH-1:0] res_data_out;
  logic                  res_valid_out;
  logic                  res_ready_in;

  modport master (
    output req_valid_in, req_osr_in, req_count_in, res_ready_in,
    input  req_ready_out, res_data_out, res_valid_out
  );

  modport slave (
    input  req_valid_in, req_osr_in, req_count_in, res_ready_in,
    output req_ready_out, res_data_out, res_valid_out
  );
endinterface

// File: rtl/vco_adc_seq_sync_fifo.sv
// Result FIFO: power-of-two depth, wrap-bit pointers, head read from storage registers.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/vco_adc_seq.sv
// Conversion sequencer: runs one burst on vco_adc, collects the requested sample count into the result FIFO.
module vco_adc_seq
  import vco_adc_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OSR_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TO_MARGIN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  vco_adc_seq_if.slave          bus,
  input  logic                  abort_in,
  output logic                  adc_enable_out,
  output logic [OSR_WIDTH-1:0]  adc_oversample_out,
  input  logic [DATA_WIDTH-1:0] adc_data_in,
  input  logic                  adc_valid_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [1:0]            status_out
);
  localparam int unsigned WIN_WIDTH = OSR_WIDTH + 4;

  state_t                state;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [WIN_WIDTH-1:0]  timer;
  logic [WIN_WIDTH-1:0]  window;
  logic                  req_ready;
  logic                  sample_take;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign sample_take       = (state == ST_RUN) && adc_valid_in && (remaining != '0);
  assign pop               = bus.res_ready_in && !fifo_empty;
  assign bus.res_valid_out = !fifo_empty;
  assign bus.res_data_out  = fifo_head;
  assign bus.req_ready_out = req_ready;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (sample_take),
    .push_data(adc_data_in),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Burst FSM with registered handshake, enable, busy, done and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      adc_enable_out     <= 1'b0;
      adc_oversample_out <= '0;
      req_ready          <= 1'b1;
      busy_out           <= 1'b0;
      done_out           <= 1'b0;
      status_out         <= '0;
      remaining          <= '0;
      timer              <= '0;
      window             <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid_in) begin
            adc_oversample_out <= bus.req_osr_in;
            remaining          <= bus.req_count_in;
            window             <= {1'b0, bus.req_osr_in, 3'b000} + WIN_WIDTH'(TO_MARGIN);
            timer              <= '0;
            status_out         <= '0;
            req_ready          <= 1'b0;
            busy_out           <= 1'b1;
            if (bus.req_count_in != '0) begin
              state          <= ST_RUN;
              adc_enable_out <= 1'b1;
            end else begin
              state    <= ST_DONE;
              done_out <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          timer <= timer + 1'b1;
          if (sample_take) begin
            remaining <= remaining - 1'b1;
            timer     <= '0;
            if (fifo_full && !pop) status_out[STAT_OVR] <= 1'b1;
          end
          // Last sample outranks abort, abort outranks timeout
          if ((sample_take && remaining == CNT_WIDTH'(1)) || abort_in) begin
            state          <= ST_DONE;
            adc_enable_out <= 1'b0;
            done_out       <= 1'b1;
          end else if (!sample_take && timer == window - WIN_WIDTH'(1)) begin
            status_out[STAT_TO] <= 1'b1;
            state               <= ST_DONE;
            adc_enable_out      <= 1'b0;
            done_out            <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy_out  <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          adc_enable_out <= 1'b0;
          req_ready      <= 1'b1;
          busy_out       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vco_adc_seq.sv
// Randomised scoreboard bench for vco_adc_seq; the bench itself plays the ADC and the result consumer.
module tb_vco_adc_seq;
  localparam int unsigned DW     = 32;
  localparam int unsigned OW     = 10;
  localparam int unsigned CW     = 16;
  localparam int          DEPTH  = 4;
  localparam int          MARGIN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          abort_in = 1'b0;
  logic          adc_valid_in = 1'b0;
  logic [DW-1:0] adc_data_in = '0;
  logic          adc_enable_out;
  logic [OW-1:0] adc_oversample_out;
  logic          busy_out;
  logic          done_out;
  logic [1:0]    status_out;

  vco_adc_seq_if #(.DATA_WIDTH(DW), .OSR_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

  vco_adc_seq #(
    .DATA_WIDTH(DW), .OSR_WIDTH(OW), .CNT_WIDTH(CW),
    .FIFO_DEPTH(DEPTH), .TO_MARGIN(MARGIN)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .abort_in          (abort_in),
    .adc_enable_out    (adc_enable_out),
    .adc_oversample_out(adc_oversample_out),
    .adc_data_in       (adc_data_in),
    .adc_valid_in      (adc_valid_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .status_out        (status_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [1:0] st;
  } done_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            occ = 0;      // model FIFO occupancy after the upcoming edge
  int            occ_now = 0;  // model FIFO occupancy in the current cycle
  bit            ovr_m = 1'b0;
  bit            mon_en = 1'b0;
  int            cur_osr = 0;
  logic [DW-1:0] exp_q[$];
  done_t         done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic rnd(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // Result monitor: valid flag against model occupancy, data against scoreboard on each pop
  always @(negedge clk) begin
    if (mon_en) begin
      chk("res_valid", bus.res_valid_out, occ_now != 0);
      if (bus.res_valid_out && bus.res_ready_in) begin
        if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
        else                   chk("res_data", bus.res_data_out, exp_q.pop_front());
      end
      if (adc_enable_out) chk("osr_hold", adc_oversample_out, cur_osr);
    end
  end

  // Completion monitor: done pulse timing, status and enable state
  always @(negedge clk) begin
    if (mon_en) begin
      if (done_out) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          done_t r;
          r = done_q.pop_front();
          chk("done_cycle", cyc, r.at);
          chk("done_status", status_out, r.st);
          chk("enable_at_done", adc_enable_out, 0);
        end
      end else if (done_q.size() != 0 && cyc >= done_q[0].at) begin
        chk("done_missing", 0, 1);
        void'(done_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; cnt marks a sample the model expects to be counted
  task automatic step(input logic v, input logic [DW-1:0] d, input bit cnt,
                      input logic ab, input logic rdy);
    bit pop;
    adc_valid_in     = v;
    adc_data_in      = d;
    abort_in         = ab;
    bus.res_ready_in = rdy;
    occ_now = occ;
    pop = (occ > 0) && rdy;
    if (cnt) begin
      if (occ < DEPTH || pop) begin
        exp_q.push_back(d);
        occ++;
      end else ovr_m = 1'b1;
    end
    if (pop) occ--;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with stray ADC valids and aborts that must be ignored
  task automatic drain(input int n, input int pct);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(1, 0)), $urandom, 0, 1'($urandom_range(1, 0)), rnd(pct));
  endtask

  task automatic flush();
    for (int i = 0; i < 64 && occ != 0; i++) step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
  endtask

  // One burst; first<0 means the ADC never responds, rst_at>=0 resets mid-run
  task automatic burst(input int osr, input int count, input int first, input int gap_lo,
                       input int gap_hi, input int abort_at, input int rdy_pct, input int rst_at);
    int a, win, tref, got, nextv;
    bit v, ab, to, fin;
    logic [DW-1:0] d;
    done_t r;
    cur_osr = osr;
    ovr_m   = 1'b0;
    chk("ready_idle", bus.req_ready_out, 1);
    bus.req_valid_in = 1'b1;
    bus.req_osr_in   = OW'(osr);
    bus.req_count_in = CW'(count);
    step(0, '0, 0, 0, rnd(rdy_pct));
    a = cyc;
    bus.req_valid_in = 1'b0;
    chk("busy_after_accept", busy_out, 1);
    chk("ready_after_accept", bus.req_ready_out, 0);
    chk("enable_after_accept", adc_enable_out, count != 0);
    if (count == 0) begin
      r.at = a; r.st = 2'b00;
      done_q.push_back(r);
      step(1, $urandom, 0, 0, rnd(rdy_pct));
      chk("enable_zero_count", adc_enable_out, 0);
      chk("idle_after_done", busy_out, 0);
      return;
    end
    win = osr * 8 + MARGIN;
    tref = 0; got = 0; nextv = first; fin = 1'b0;
    for (int k = 0; !fin; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        step(0, '0, 0, 0, 0);
        occ = 0; occ_now = 0;
        exp_q.delete();
        done_q.delete();
        rst = 1'b0;
        chk("rst_enable", adc_enable_out, 0);
        chk("rst_osr", adc_oversample_out, 0);
        chk("rst_ready", bus.req_ready_out, 1);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_status", status_out, 0);
        chk("rst_res_valid", bus.res_valid_out, 0);
        return;
      end
      v  = (nextv >= 0) && (k == nextv);
      ab = (k == abort_at);
      to = !v && !ab && (k - tref == win - 1);
      d  = $urandom;
      if (v) begin
        got++;
        tref  = k + 1;
        nextv = k + int'($urandom_range(gap_hi, gap_lo));
      end
      fin = (v && got == count) || ab || to;
      step(v, d, v, ab, rnd(rdy_pct));
      if (fin) begin
        r.at = a + k + 1; r.st = {to, ovr_m};
        done_q.push_back(r);
      end
    end
    chk("enable_off_in_done", adc_enable_out, 0);
    step(1, $urandom, 0, 0, rnd(rdy_pct));
    chk("idle_after_done", busy_out, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_valid_in = 1'b0;
    bus.req_osr_in   = '0;
    bus.req_count_in = '0;
    bus.res_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enable", adc_enable_out, 0);
    chk("reset_osr", adc_oversample_out, 0);
    chk("reset_ready", bus.req_ready_out, 1);
    chk("reset_busy", busy_out, 0);
    chk("reset_done", done_out, 0);
    chk("reset_status", status_out, 0);
    chk("reset_res_valid", bus.res_valid_out, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    step(0, '0, 0, 0, 0);

    // Nominal burst: startup then one word per decimation period
    burst(8, 3, 40, 8, 8, -1, 100, -1);
    drain(4, 100);
    // Zero-length command
    burst(5, 0, 0, 1, 1, -1, 100, -1);
    drain(3, 100);
    // Consumer stalled: depth words kept, the rest dropped as overrun
    flush();
    burst(2, 6, 10, 3, 5, -1, 0, -1);
    flush();
    // Silent ADC: timeout after osr*8+margin cycles
    burst(4, 5, -1, 1, 1, -1, 100, -1);
    drain(3, 100);
    // Abort partway through a longer burst, collected words stay drainable
    burst(4, 10, 5, 6, 6, 20, 0, -1);
    flush();
    // Reset in the middle of a run with two words queued, then a fresh command
    burst(3, 8, 3, 5, 5, -1, 0, 12);
    burst(1, 2, 2, 2, 4, -1, 100, -1);
    drain(3, 100);

    // Randomised bursts mixing aborts, timeouts and back-pressure
    for (int n = 0; n < 14; n++) begin
      int osr, win;
      osr = int'($urandom_range(6, 0));
      win = osr * 8 + MARGIN;
      burst(osr, int'($urandom_range(7, 0)), int'($urandom_range(win + 4, 0)), 1,
            int'($urandom_range(win + 2, 1)),
            ($urandom_range(3, 0) == 0) ? int'($urandom_range(30, 0)) : -1,
            int'($urandom_range(100, 20)), -1);
      drain(int'($urandom_range(6, 1)), 50);
    end

    flush();
    repeat (3) step(0, '0, 0, 0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
